// File: rtl/gb_psum_pkg.sv
// -----------------------------------------------------------------------------
// gb_psum_pkg
// Shared definitions for the partial-sum global-buffer (GB) write path.
// This file holds:
//   - the default requester count, beat width, address width and count width
//   - the sequencer FSM state encoding
//   - a small round-robin pointer helper
// There are no ports. The write-side top (gb_psum_wr_arb) imports this
// package, and the read side is expected to import it as well.
// -----------------------------------------------------------------------------
package gb_psum_pkg;

    // Default geometry. The PE array has 32 blocks (NUM_PEB), each with
    // 3 requesters. A beat is 16 psums of 32 bits.
    localparam int GB_NUM_REQ       = 96;
    localparam int GB_PSUMBUS_WIDTH = 512;
    localparam int GB_ADDR_WIDTH    = 8;
    localparam int GB_CNT_WIDTH     = 12;
    localparam int GB_ID_WIDTH      = 7;

    // Sequencer FSM encoding. Kept as plain constants so that it stays
    // compatible with older tools.
    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_RUN   = 2'd1;
    localparam arb_state_t ST_DRAIN = 2'd2;
    localparam arb_state_t ST_DONE  = 2'd3;

    // Next round-robin start position after index idx has been served,
    // among n requesters.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/gb_psum_wr_arb_rr_arb.sv
// -----------------------------------------------------------------------------
// rr_arb
// N-way round-robin priority picker. It is purely combinational. The search
// starts at i_ptr and wraps modulo N. The first requester found with its
// i_req bit set is the winner.
//
// Ports:
//   i_req  [N-1:0]      request vector
//   i_ptr  [IDX_W-1:0]  highest-priority position, in the range 0..N-1
//   o_gnt  [N-1:0]      one-hot grant, or all zeros when nothing requests
//   o_idx  [IDX_W-1:0]  index of the granted requester (0 when none)
//   o_any               at least one requester is active
// -----------------------------------------------------------------------------
module rr_arb
    import gb_psum_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // The scan runs in priority order: ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
    // Once the first hit is taken, o_any blocks any later hit from
    // overwriting the grant.
    always_comb begin
        int j;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(i_ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!o_any && i_req[j]) begin
                o_any    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/gb_psum_wr_arb.sv
// -----------------------------------------------------------------------------
// gb_psum_wr_arb
// Round-robin write arbiter and sequencer for the partial-sum global buffer.
//
// Operation:
//   - Collects psum beats from NUM_REQ requesters.
//   - Grants at most one beat per cycle to the single GB write port, which is
//     a registered output slot.
//   - Generates sequential write addresses.
//   - Counts accepted beats against the configured total.
//   - Pulses ARBCCU_fnh once the last beat has left the output slot.
//
// Optional feature (define the macro to build it):
//   GB_PSUM_ARB_PERF_EN  ARBPERF_conflict counts RUN cycles in which two or
//                        more requesters are valid. The count saturates and
//                        clears on rst and on config accept. When the macro
//                        is undefined, the output is tied to zero.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   CFGARB_val          config valid (level); taken in IDLE only
//   ARBCFG_rdy          high while IDLE
//   CFGARB_num_beat     beats per patch; 0 is treated as 1
//   CCUARB_reset_patch  abort pulse; returns to IDLE and drops any held beat
//   ARBCCU_fnh          one-cycle patch-done pulse (high in DONE)
//   PSUMARB_val         per-requester beat valid
//   ARBPSUM_rdy         per-requester ready; one-hot or zero
//   PSUMARB_data        requester beats; requester i uses slice i
//   ARBGB_val/GBARB_rdy GB write handshake
//   ARBGB_addr/id/data  GB write address, winning requester index, beat
//   ARBPERF_conflict    conflict counter (see above)
//
// Handshake: a transfer happens on a rising edge when valid and ready are
// both high. A producer that has raised valid keeps its payload stable until
// the transfer happens. Requesters may withdraw valid without a transfer,
// and the arbiter re-evaluates every cycle. On the GB side, ARBGB_val is
// never withdrawn except by rst or CCUARB_reset_patch.
// -----------------------------------------------------------------------------
module gb_psum_wr_arb
    import gb_psum_pkg::*;
#(
    parameter int NUM_REQ       = GB_NUM_REQ,
    parameter int PSUMBUS_WIDTH = GB_PSUMBUS_WIDTH,
    parameter int ADDR_WIDTH    = GB_ADDR_WIDTH,
    parameter int CNT_WIDTH     = GB_CNT_WIDTH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               CFGARB_val,
    output logic                               ARBCFG_rdy,
    input  logic [CNT_WIDTH-1:0]               CFGARB_num_beat,
    input  logic                               CCUARB_reset_patch,
    output logic                               ARBCCU_fnh,
    input  logic [NUM_REQ-1:0]                 PSUMARB_val,
    output logic [NUM_REQ-1:0]                 ARBPSUM_rdy,
    input  logic [NUM_REQ*PSUMBUS_WIDTH-1:0]   PSUMARB_data,
    output logic                               ARBGB_val,
    input  logic                               GBARB_rdy,
    output logic [ADDR_WIDTH-1:0]              ARBGB_addr,
    output logic [GB_ID_WIDTH-1:0]             ARBGB_id,
    output logic [PSUMBUS_WIDTH-1:0]           ARBGB_data,
    output logic [15:0]                        ARBPERF_conflict
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    arb_state_t                r_state;
    arb_state_t                w_state_nxt;
    logic [CNT_WIDTH-1:0]      r_num_beat;
    logic [CNT_WIDTH-1:0]      r_beat_cnt;
    logic [ADDR_WIDTH-1:0]     r_addr_cnt;
    logic [IDX_W-1:0]          r_ptr;

    logic                      r_gb_val;
    logic [ADDR_WIDTH-1:0]     r_gb_addr;
    logic [GB_ID_WIDTH-1:0]    r_gb_id;
    logic [PSUMBUS_WIDTH-1:0]  r_gb_data;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0]        w_gnt;
    logic [IDX_W-1:0]          w_gnt_idx;
    logic                      w_any;
    logic                      w_slot_ok;
    logic                      w_beats_left;
    logic                      w_grant_en;
    logic                      w_accept;
    logic                      w_last_accept;
    logic                      w_cfg_accept;
    logic [CNT_WIDTH-1:0]      w_num_beat_fixed;
    logic [IDX_W-1:0]          w_ptr_nxt;
    logic [PSUMBUS_WIDTH-1:0]  w_sel_data;

    rr_arb #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arb (
        .i_req (PSUMARB_val),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx),
        .o_any (w_any)
    );

    // The output slot can take a new beat when it is empty, or when the
    // beat it holds leaves this same cycle.
    assign w_slot_ok    = !r_gb_val || GBARB_rdy;
    // Once the final beat is counted, no further ready is issued. This also
    // covers a num_beat that never moved past zero.
    assign w_beats_left = (r_beat_cnt < r_num_beat);
    assign w_grant_en   = (r_state == ST_RUN) && w_beats_left && w_slot_ok;

    assign ARBPSUM_rdy   = w_grant_en ? w_gnt : '0;
    assign w_accept      = w_grant_en && w_any;
    assign w_last_accept = w_accept &&
                           ((r_beat_cnt + CNT_WIDTH'(1)) == r_num_beat);

    // Reset_patch in the same cycle as a config blocks the config. The
    // config is taken again on the next IDLE cycle if it is still asserted.
    assign w_cfg_accept  = (r_state == ST_IDLE) && CFGARB_val &&
                           !CCUARB_reset_patch;

    assign w_num_beat_fixed = (CFGARB_num_beat == '0) ? CNT_WIDTH'(1)
                                                      : CFGARB_num_beat;

    assign w_ptr_nxt = IDX_W'(rr_next(int'(w_gnt_idx), NUM_REQ));

    assign w_sel_data = PSUMARB_data[int'(w_gnt_idx)*PSUMBUS_WIDTH +: PSUMBUS_WIDTH];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (CFGARB_val) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // The !w_beats_left term is only a safety exit. It keeps the
                // FSM from stalling in RUN if the counters ever disagree.
                if (w_last_accept || !w_beats_left) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_slot_ok) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (CCUARB_reset_patch) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Sequential control, counters and output slot
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_num_beat <= CNT_WIDTH'(1);
            r_beat_cnt <= '0;
            r_addr_cnt <= '0;
            r_ptr      <= '0;
            r_gb_val   <= 1'b0;
            r_gb_addr  <= '0;
            r_gb_id    <= '0;
            r_gb_data  <= '0;
        end else if (CCUARB_reset_patch) begin
            // Abort. A beat held in the slot is dropped, and a beat offered
            // in this same cycle is not taken.
            r_state    <= ST_IDLE;
            r_beat_cnt <= '0;
            r_addr_cnt <= '0;
            r_ptr      <= '0;
            r_gb_val   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_cfg_accept) begin
                r_num_beat <= w_num_beat_fixed;
                r_beat_cnt <= '0;
                r_addr_cnt <= '0;
                r_ptr      <= '0;
            end

            if (w_accept) begin
                r_gb_val   <= 1'b1;
                r_gb_addr  <= r_addr_cnt;
                r_gb_id    <= GB_ID_WIDTH'(w_gnt_idx);
                r_gb_data  <= w_sel_data;
                r_addr_cnt <= r_addr_cnt + ADDR_WIDTH'(1);
                r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
                r_ptr      <= w_ptr_nxt;
            end else if (GBARB_rdy) begin
                r_gb_val <= 1'b0;
            end
        end
    end

    assign ARBCFG_rdy = (r_state == ST_IDLE);
    assign ARBCCU_fnh = (r_state == ST_DONE);
    assign ARBGB_val  = r_gb_val;
    assign ARBGB_addr = r_gb_addr;
    assign ARBGB_id   = r_gb_id;
    assign ARBGB_data = r_gb_data;

    // ------------------------------------------------------------------
    // Conflict counter
    // ------------------------------------------------------------------
`ifdef GB_PSUM_ARB_PERF_EN
    logic [15:0] r_conflict;
    logic        w_multi_req;

    // Clearing the lowest set bit leaves a nonzero vector only when at
    // least two bits were set.
    assign w_multi_req = |(PSUMARB_val & (PSUMARB_val - NUM_REQ'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_conflict <= '0;
        end else if (w_cfg_accept) begin
            r_conflict <= '0;
        end else if ((r_state == ST_RUN) && w_multi_req &&
                     (r_conflict != 16'hFFFF)) begin
            r_conflict <= r_conflict + 16'd1;
        end
    end

    assign ARBPERF_conflict = r_conflict;
`else
    assign ARBPERF_conflict = '0;
`endif

endmodule

// File: tb/tb_gb_psum_wr_arb.sv
// -----------------------------------------------------------------------------
// tb_gb_psum_wr_arb
// Directed bench for gb_psum_wr_arb, using the default parameters.
// Inputs are driven just after the falling edge, and outputs are sampled
// there as well.
// -----------------------------------------------------------------------------
module tb_gb_psum_wr_arb;

  localparam int NREQ = 96;
  localparam int BW   = 512;

  logic              clk;
  logic              rst;
  logic              CFGARB_val;
  logic              ARBCFG_rdy;
  logic [11:0]       CFGARB_num_beat;
  logic              CCUARB_reset_patch;
  logic              ARBCCU_fnh;
  logic [NREQ-1:0]   PSUMARB_val;
  logic [NREQ-1:0]   ARBPSUM_rdy;
  logic [NREQ*BW-1:0] PSUMARB_data;
  logic              ARBGB_val;
  logic              GBARB_rdy;
  logic [7:0]        ARBGB_addr;
  logic [6:0]        ARBGB_id;
  logic [BW-1:0]     ARBGB_data;
  logic [15:0]       ARBPERF_conflict;

  int n_cmp;
  int n_err;

  // Beats observed on the GB port, plus the cycles that carried fnh.
  logic [7:0]    obs_addr[$];
  logic [6:0]    obs_id[$];
  logic [BW-1:0] obs_data[$];
  int            obs_cyc[$];
  int            fnh_q[$];
  logic [6:0]    exp_q[$];

  gb_psum_wr_arb dut (
    .clk                (clk),
    .rst                (rst),
    .CFGARB_val         (CFGARB_val),
    .ARBCFG_rdy         (ARBCFG_rdy),
    .CFGARB_num_beat    (CFGARB_num_beat),
    .CCUARB_reset_patch (CCUARB_reset_patch),
    .ARBCCU_fnh         (ARBCCU_fnh),
    .PSUMARB_val        (PSUMARB_val),
    .ARBPSUM_rdy        (ARBPSUM_rdy),
    .PSUMARB_data       (PSUMARB_data),
    .ARBGB_val          (ARBGB_val),
    .GBARB_rdy          (GBARB_rdy),
    .ARBGB_addr         (ARBGB_addr),
    .ARBGB_id           (ARBGB_id),
    .ARBGB_data         (ARBGB_data),
    .ARBPERF_conflict   (ARBPERF_conflict)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Distinct per-requester beat pattern
  function automatic logic [BW-1:0] pat(input int i);
    logic [BW-1:0] r;
    for (int k = 0; k < 16; k++) begin
      r[k*32 +: 32] = 32'(i) * 32'h0100_0193 + 32'(k) + 32'h5A00_0000;
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // Call right after a falling edge while the DUT is IDLE. The task returns
  // one falling edge later, and by then the config has been taken.
  task automatic cfg(input int nb);
    CFGARB_num_beat = 12'(nb);
    CFGARB_val      = 1'b1;
    @(negedge clk);
    CFGARB_val      = 1'b0;
  endtask

  task automatic settle();
    PSUMARB_val        = '0;
    GBARB_rdy          = 1'b1;
    CFGARB_val         = 1'b0;
    CCUARB_reset_patch = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Records GB-side transfers and fnh pulses. It stops two cycles after the
  // first fnh or when the cycle budget runs out.
  task automatic collect(input int max_cyc);
    obs_addr.delete();
    obs_id.delete();
    obs_data.delete();
    obs_cyc.delete();
    fnh_q.delete();
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (ARBGB_val && GBARB_rdy) begin
        obs_addr.push_back(ARBGB_addr);
        obs_id.push_back(ARBGB_id);
        obs_data.push_back(ARBGB_data);
        obs_cyc.push_back(c);
      end
      if (ARBCCU_fnh) fnh_q.push_back(c);
      if (fnh_q.size() > 0 && c >= fnh_q[0] + 2) break;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    PSUMARB_val = '1;
    repeat (3) @(negedge clk);
    n_cmp++; if (ARBCFG_rdy !== 1'b1) begin n_err++; $display("FAIL reset_cfg_rdy got=%0b exp=1", ARBCFG_rdy); end
    n_cmp++; if (ARBPSUM_rdy !== '0) begin n_err++; $display("FAIL reset_psum_rdy got=%h exp=0", ARBPSUM_rdy); end
    n_cmp++; if (ARBGB_val !== 1'b0) begin n_err++; $display("FAIL reset_gb_val got=%0b exp=0", ARBGB_val); end
    n_cmp++; if (ARBGB_addr !== 8'd0 || ARBGB_id !== 7'd0) begin n_err++; $display("FAIL reset_addr_id got=%0d/%0d exp=0/0", ARBGB_addr, ARBGB_id); end
    n_cmp++; if (ARBGB_data !== '0) begin n_err++; $display("FAIL reset_data got nonzero exp=0"); end
    n_cmp++; if (ARBCCU_fnh !== 1'b0 || ARBPERF_conflict !== 16'd0) begin n_err++; $display("FAIL reset_fnh_perf got=%0b/%0d exp=0/0", ARBCCU_fnh, ARBPERF_conflict); end
    rst = 1'b0;
    settle();
  endtask

  task automatic test_basic();
    logic [NREQ-1:0] e_rdy;
    e_rdy = '0; e_rdy[5] = 1'b1;
    PSUMARB_val = '0; PSUMARB_val[5] = 1'b1;
    cfg(4);
    #1;
    n_cmp++; if (ARBPSUM_rdy !== e_rdy) begin n_err++; $display("FAIL basic_rdy got=%h exp=%h", ARBPSUM_rdy, e_rdy); end
    n_cmp++; if (ARBCFG_rdy !== 1'b0) begin n_err++; $display("FAIL basic_cfg_rdy_run got=%0b exp=0", ARBCFG_rdy); end
    collect(30);
    n_cmp++; if (obs_addr.size() != 4) begin n_err++; $display("FAIL basic_count got=%0d exp=4", obs_addr.size()); end
    for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
      n_cmp++; if (obs_addr[i] !== 8'(i) || obs_id[i] !== 7'd5 || obs_data[i] !== pat(5))
        begin n_err++; $display("FAIL basic_beat%0d got addr=%0d id=%0d exp addr=%0d id=5", i, obs_addr[i], obs_id[i], i); end
      n_cmp++; if (obs_cyc[i] != i) begin n_err++; $display("FAIL basic_cycle%0d got=%0d exp=%0d", i, obs_cyc[i], i); end
    end
    n_cmp++; if (fnh_q.size() != 1) begin n_err++; $display("FAIL basic_fnh_pulses got=%0d exp=1", fnh_q.size()); end
    n_cmp++; if (fnh_q.size() == 0 || obs_cyc.size() == 0 || fnh_q[0] - obs_cyc[$] != 1)
      begin n_err++; $display("FAIL basic_fnh_timing got fnh_q=%p last=%p exp=last+1", fnh_q, obs_cyc); end
    n_cmp++; if (ARBCFG_rdy !== 1'b1) begin n_err++; $display("FAIL basic_back_idle got=%0b exp=1", ARBCFG_rdy); end
    settle();
  endtask

  task automatic test_rr_order();
    logic [15:0] e_conf;
    exp_q.delete();
    exp_q.push_back(7'd0); exp_q.push_back(7'd1); exp_q.push_back(7'd95);
    exp_q.push_back(7'd0); exp_q.push_back(7'd1); exp_q.push_back(7'd95);
    PSUMARB_val = '0;
    PSUMARB_val[0] = 1'b1; PSUMARB_val[1] = 1'b1; PSUMARB_val[95] = 1'b1;
    cfg(6);
    collect(40);
    n_cmp++; if (obs_id.size() != 6) begin n_err++; $display("FAIL rr_count got=%0d exp=6", obs_id.size()); end
    for (int i = 0; i < obs_id.size() && exp_q.size() > 0; i++) begin
      logic [6:0] e;
      e = exp_q.pop_front();
      n_cmp++; if (obs_id[i] !== e || obs_addr[i] !== 8'(i) || obs_data[i] !== pat(int'(e)))
        begin n_err++; $display("FAIL rr_beat%0d got id=%0d addr=%0d exp id=%0d addr=%0d", i, obs_id[i], obs_addr[i], e, i); end
    end
`ifdef GB_PSUM_ARB_PERF_EN
    e_conf = 16'd6;
`else
    e_conf = 16'd0;
`endif
    n_cmp++; if (ARBPERF_conflict !== e_conf) begin n_err++; $display("FAIL rr_conflict got=%0d exp=%0d", ARBPERF_conflict, e_conf); end
    n_cmp++; if (fnh_q.size() != 1) begin n_err++; $display("FAIL rr_fnh got=%0d exp=1", fnh_q.size()); end
    settle();
  endtask

  task automatic test_backpressure();
    logic [NREQ-1:0] e_rdy;
    e_rdy = '0; e_rdy[7] = 1'b1;
    PSUMARB_val = '0; PSUMARB_val[7] = 1'b1;
    cfg(4);
    @(negedge clk);
    GBARB_rdy = 1'b0;
    #1;
    n_cmp++; if (ARBGB_val !== 1'b1 || ARBGB_addr !== 8'd0) begin n_err++; $display("FAIL bp_first got val=%0b addr=%0d exp val=1 addr=0", ARBGB_val, ARBGB_addr); end
    n_cmp++; if (ARBPSUM_rdy !== '0) begin n_err++; $display("FAIL bp_rdy_low got=%h exp=0", ARBPSUM_rdy); end
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      n_cmp++; if (ARBGB_val !== 1'b1 || ARBGB_addr !== 8'd0 || ARBGB_id !== 7'd7 || ARBGB_data !== pat(7))
        begin n_err++; $display("FAIL bp_hold%0d got val=%0b addr=%0d id=%0d exp val=1 addr=0 id=7", h, ARBGB_val, ARBGB_addr, ARBGB_id); end
      n_cmp++; if (ARBPSUM_rdy !== '0) begin n_err++; $display("FAIL bp_hold_rdy%0d got=%h exp=0", h, ARBPSUM_rdy); end
    end
    GBARB_rdy = 1'b1;
    #1;
    n_cmp++; if (ARBPSUM_rdy !== e_rdy) begin n_err++; $display("FAIL bp_resume_rdy got=%h exp=%h", ARBPSUM_rdy, e_rdy); end
    collect(30);
    n_cmp++; if (obs_addr.size() != 3) begin n_err++; $display("FAIL bp_rest_count got=%0d exp=3", obs_addr.size()); end
    for (int i = 0; i < obs_addr.size() && i < 3; i++) begin
      n_cmp++; if (obs_addr[i] !== 8'(i + 1) || obs_id[i] !== 7'd7)
        begin n_err++; $display("FAIL bp_rest%0d got addr=%0d id=%0d exp addr=%0d id=7", i, obs_addr[i], obs_id[i], i + 1); end
    end
    n_cmp++; if (fnh_q.size() == 0 || obs_cyc.size() == 0 || fnh_q[0] - obs_cyc[$] != 1)
      begin n_err++; $display("FAIL bp_fnh_timing got fnh_q=%p last=%p exp=last+1", fnh_q, obs_cyc); end
    settle();
  endtask

  task automatic test_zero_beat();
    PSUMARB_val = '0; PSUMARB_val[3] = 1'b1;
    cfg(0);
    collect(20);
    n_cmp++; if (obs_addr.size() != 1) begin n_err++; $display("FAIL zero_count got=%0d exp=1", obs_addr.size()); end
    n_cmp++; if (obs_addr.size() == 0 || obs_addr[0] !== 8'd0 || obs_id[0] !== 7'd3)
      begin n_err++; $display("FAIL zero_beat got size=%0d exp addr=0 id=3", obs_addr.size()); end
    n_cmp++; if (fnh_q.size() != 1 || fnh_q[0] != 1) begin n_err++; $display("FAIL zero_fnh got=%p exp={1}", fnh_q); end
    settle();
  endtask

  task automatic test_addr_wrap();
    int bad;
    bad = 0;
    PSUMARB_val = '0; PSUMARB_val[10] = 1'b1;
    cfg(300);
    collect(400);
    n_cmp++; if (obs_addr.size() != 300) begin n_err++; $display("FAIL wrap_count got=%0d exp=300", obs_addr.size()); end
    for (int i = 0; i < obs_addr.size(); i++) begin
      if (obs_addr[i] !== 8'(i % 256) || obs_id[i] !== 7'd10) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL wrap_sequence got=%0d bad beats exp=0", bad); end
    n_cmp++; if (obs_addr.size() <= 256 || obs_addr[256] !== 8'd0 || obs_addr[255] !== 8'd255)
      begin n_err++; $display("FAIL wrap_point got size=%0d exp beat255=255 beat256=0", obs_addr.size()); end
    n_cmp++; if (fnh_q.size() == 0 || obs_cyc.size() == 0 || fnh_q[0] - obs_cyc[$] != 1)
      begin n_err++; $display("FAIL wrap_fnh got fnh_q=%p exp=last+1", fnh_q); end
    settle();
  endtask

  task automatic test_reset_patch();
    int fnh_seen;
    int val_seen;
    PSUMARB_val = '0; PSUMARB_val[2] = 1'b1;
    cfg(8);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (ARBGB_val !== 1'b1 || ARBGB_addr !== 8'd1) begin n_err++; $display("FAIL rp_pre got val=%0b addr=%0d exp val=1 addr=1", ARBGB_val, ARBGB_addr); end
    CCUARB_reset_patch = 1'b1;
    @(negedge clk);
    CCUARB_reset_patch = 1'b0;
    n_cmp++; if (ARBCFG_rdy !== 1'b1 || ARBGB_val !== 1'b0 || ARBCCU_fnh !== 1'b0)
      begin n_err++; $display("FAIL rp_abort got cfg_rdy=%0b val=%0b fnh=%0b exp 1/0/0", ARBCFG_rdy, ARBGB_val, ARBCCU_fnh); end
    fnh_seen = 0; val_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ARBCCU_fnh) fnh_seen++;
      if (ARBGB_val || ARBPSUM_rdy != '0) val_seen++;
    end
    n_cmp++; if (fnh_seen != 0 || val_seen != 0) begin n_err++; $display("FAIL rp_quiet got fnh=%0d act=%0d exp=0/0", fnh_seen, val_seen); end
    // Config in the same cycle as reset_patch must be blocked.
    CFGARB_num_beat = 12'd2;
    CFGARB_val = 1'b1;
    CCUARB_reset_patch = 1'b1;
    @(negedge clk);
    CCUARB_reset_patch = 1'b0;
    n_cmp++; if (ARBCFG_rdy !== 1'b1) begin n_err++; $display("FAIL rp_cfg_blocked got=%0b exp=1", ARBCFG_rdy); end
    @(negedge clk);
    CFGARB_val = 1'b0;
    n_cmp++; if (ARBCFG_rdy !== 1'b0) begin n_err++; $display("FAIL rp_cfg_taken got=%0b exp=0", ARBCFG_rdy); end
    collect(20);
    n_cmp++; if (obs_addr.size() != 2) begin n_err++; $display("FAIL rp_restart_count got=%0d exp=2", obs_addr.size()); end
    n_cmp++; if (obs_addr.size() < 2 || obs_addr[0] !== 8'd0 || obs_addr[1] !== 8'd1 || obs_id[0] !== 7'd2)
      begin n_err++; $display("FAIL rp_restart_addr got size=%0d exp addrs 0,1 id 2", obs_addr.size()); end
    n_cmp++; if (fnh_q.size() != 1) begin n_err++; $display("FAIL rp_restart_fnh got=%0d exp=1", fnh_q.size()); end
    settle();
  endtask

  task automatic test_rst_drain();
    int fnh_seen;
    PSUMARB_val = '0; PSUMARB_val[9] = 1'b1;
    cfg(2);
    @(negedge clk);
    @(negedge clk);
    GBARB_rdy = 1'b0;
    @(negedge clk);
    n_cmp++; if (ARBGB_val !== 1'b1 || ARBGB_addr !== 8'd1 || ARBCCU_fnh !== 1'b0 || ARBCFG_rdy !== 1'b0)
      begin n_err++; $display("FAIL rd_drain got val=%0b addr=%0d fnh=%0b cfg_rdy=%0b exp 1/1/0/0", ARBGB_val, ARBGB_addr, ARBCCU_fnh, ARBCFG_rdy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    GBARB_rdy = 1'b1;
    n_cmp++; if (ARBCFG_rdy !== 1'b1 || ARBPSUM_rdy !== '0 || ARBGB_val !== 1'b0 || ARBCCU_fnh !== 1'b0)
      begin n_err++; $display("FAIL rd_ctrl got cfg_rdy=%0b rdy=%h val=%0b fnh=%0b exp 1/0/0/0", ARBCFG_rdy, ARBPSUM_rdy, ARBGB_val, ARBCCU_fnh); end
    n_cmp++; if (ARBGB_addr !== 8'd0 || ARBGB_id !== 7'd0 || ARBGB_data !== '0 || ARBPERF_conflict !== 16'd0)
      begin n_err++; $display("FAIL rd_data got addr=%0d id=%0d perf=%0d exp 0/0/0", ARBGB_addr, ARBGB_id, ARBPERF_conflict); end
    fnh_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ARBCCU_fnh) fnh_seen++;
    end
    n_cmp++; if (fnh_seen != 0) begin n_err++; $display("FAIL rd_no_fnh got=%0d exp=0", fnh_seen); end
    settle();
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    CFGARB_val = 1'b0;
    CFGARB_num_beat = '0;
    CCUARB_reset_patch = 1'b0;
    PSUMARB_val = '0;
    GBARB_rdy = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      PSUMARB_data[i*BW +: BW] = pat(i);
    end
    test_reset();
    test_basic();
    test_rr_order();
    test_backpressure();
    test_zero_beat();
    test_addr_wrap();
    test_reset_patch();
    test_rst_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
